// File: rtl/bit_serial_dot_engine.sv
// rtl/bit_serial_dot_engine.sv - bit-serial signed dot-product engine with saturating accumulator
//
// Accepts one vector of LANES signed activations and weights per handshake.
// Walks the low N weight bits LSB first, adding shifted activations (and
// subtracting on the sign bit). Sums the lanes and accumulates them with
// saturation until a vector flagged last closes the dot product.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   in_valid/in_ready    vector handshake (ready only while idle)
//   in_act[LANES*AW]     signed activations, lane i at [i*AW +: AW]
//   in_wgt[LANES*WW]     signed weights, lane i at [i*WW +: WW]
//   in_prec[2]           weight precision select (0/3: WW, 1: WW/2, 2: WW/4)
//   in_last              vector closes the current dot product
//   out_valid/out_ready  result handshake
//   out_result[ACCW]     accumulator value (meaningful while out_valid)
//   out_ovf              sticky saturation flag for the current dot product
//   busy                 engine not idle
module bit_serial_dot_engine #(
    parameter int AW    = 8,
    parameter int WW    = 8,
    parameter int LANES = 4,
    parameter int ACCW  = 20
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*AW-1:0]      in_act,
    input  logic [LANES*WW-1:0]      in_wgt,
    input  logic [1:0]               in_prec,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACCW-1:0]          out_result,
    output logic                     out_ovf,
    output logic                     busy
);

    localparam int PW = AW + WW;
    localparam int SW = AW + WW + $clog2(LANES);
    localparam int CW = $clog2(WW + 1);
    localparam int EW = ACCW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_ACC,
        S_HOLD
    } state_t;

    state_t                    r_state;
    logic [LANES*AW-1:0]       r_act;
    logic [LANES*WW-1:0]       r_wgt;
    logic [CW-1:0]             r_n;
    logic [CW-1:0]             r_cnt;
    logic                      r_last;
    logic signed [PW-1:0]      r_psum [LANES];
    logic signed [ACCW-1:0]    r_acc;
    logic                      r_ovf;
    logic                      r_out_valid;

    logic [CW-1:0]             w_n;
    logic                      w_msb;
    logic signed [PW-1:0]      w_psum_nxt [LANES];
    logic signed [SW-1:0]      w_dot;
    logic signed [EW-1:0]      w_acc_sum;
    logic                      w_sat;
    logic signed [ACCW-1:0]    w_acc_nxt;

    always_comb begin
        case (in_prec)
            2'd1:    w_n = CW'(WW / 2);
            2'd2:    w_n = CW'(WW / 4);
            default: w_n = CW'(WW);
        endcase
    end

    // The weight bit at position N-1 is the sign bit and carries negative weight.
    assign w_msb = (r_cnt == (r_n - CW'(1)));

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [PW-1:0] w_act_ext;
            logic signed [PW-1:0] w_term;
            logic [WW-1:0]        w_wlane;
            logic                 w_bit;

            assign w_act_ext = PW'($signed(r_act[gi*AW +: AW]));
            assign w_term    = w_act_ext <<< r_cnt;
            assign w_wlane   = r_wgt[gi*WW +: WW];
            assign w_bit     = |(w_wlane & (WW'(1) << r_cnt));

            assign w_psum_nxt[gi] = !w_bit ? r_psum[gi] :
                                    (w_msb ? (r_psum[gi] - w_term) : (r_psum[gi] + w_term));
        end
    endgenerate

    always_comb begin
        w_dot = '0;
        for (int i = 0; i < LANES; i++) begin
            w_dot = w_dot + SW'(r_psum[i]);
        end
    end

    // One extra bit holds any sum of two ACCW values; differing top bits mean overflow.
    assign w_acc_sum = EW'(r_acc) + EW'(w_dot);
    assign w_sat     = w_acc_sum[EW-1] ^ w_acc_sum[EW-2];

    always_comb begin
        if (!w_sat) begin
            w_acc_nxt = w_acc_sum[ACCW-1:0];
        end else if (w_acc_sum[EW-1]) begin
            w_acc_nxt = {1'b1, {(ACCW-1){1'b0}}};
        end else begin
            w_acc_nxt = {1'b0, {(ACCW-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_act       <= '0;
            r_wgt       <= '0;
            r_n         <= '0;
            r_cnt       <= '0;
            r_last      <= 1'b0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_psum[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_act   <= in_act;
                        r_wgt   <= in_wgt;
                        r_n     <= w_n;
                        r_last  <= in_last;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                        for (int i = 0; i < LANES; i++) begin
                            r_psum[i] <= '0;
                        end
                    end
                end
                S_SHIFT: begin
                    for (int i = 0; i < LANES; i++) begin
                        r_psum[i] <= w_psum_nxt[i];
                    end
                    if (w_msb) begin
                        r_state <= S_ACC;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_ACC: begin
                    r_acc <= w_acc_nxt;
                    if (w_sat) begin
                        r_ovf <= 1'b1;
                    end
                    if (r_last) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_acc       <= '0;
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign out_valid  = r_out_valid;
    assign out_result = r_acc;
    assign out_ovf    = r_ovf;

endmodule

// File: tb/tb_bit_serial_dot_engine.sv
// tb/tb_bit_serial_dot_engine.sv - directed table-driven bench for bit_serial_dot_engine
module tb_bit_serial_dot_engine;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_act;
    logic [31:0] in_wgt;
    logic [1:0]  in_prec;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_result;
    logic        out_ovf;
    logic        busy;

    int checks = 0;
    int fails  = 0;

    bit_serial_dot_engine #(.AW(8), .WW(8), .LANES(4), .ACCW(20)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_act     (in_act),
        .in_wgt     (in_wgt),
        .in_prec    (in_prec),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] act;
        logic [31:0] wgt;
        logic [1:0]  prec;
        logic        last;
        logic [19:0] exp_res;
        logic        exp_ovf;
        int          exp_lat;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [31:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Offers one vector, then counts edges after acceptance until the result
    // (last) or renewed readiness (not last) appears. lat = -1 on timeout.
    task automatic send(input logic [31:0] act, input logic [31:0] wgt, input logic [1:0] prec,
                        input logic last, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        lat = -1;
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            in_valid = 1'b1;
            in_act   = act;
            in_wgt   = wgt;
            in_prec  = prec;
            in_last  = last;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_act   = ~act;
            in_wgt   = ~wgt;
            in_prec  = ~prec;
            in_last  = ~last;
            for (int c = 1; c <= 40; c++) begin
                @(posedge clk);
                #1;
                if (last ? out_valid : in_ready) begin
                    lat = c;
                    break;
                end
            end
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hs_out_valid", 32'(out_valid), 32'd0);
        check("hs_result", 32'(out_result), 32'd0);
        check("hs_ovf", 32'(out_ovf), 32'd0);
        check("hs_in_ready", 32'(in_ready), 32'd1);
        check("hs_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        logic [19:0] held;

        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_act    = '0;
        in_wgt    = '0;
        in_prec   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        tbl[0] = '{pk(3, -2, 5, 1), pk(4, 7, -1, -128), 2'd0, 1'b1, 20'hFFF79, 1'b0, 9};
        tbl[1] = '{pk(5, 5, 5, 5), pk(8'hAF, 8'h0F, 8'h3F, 8'hFF), 2'd1, 1'b1, 20'hFFFEC, 1'b0, 5};
        tbl[2] = '{pk(1, 1, 1, 1), pk(2, 2, 2, 2), 2'd0, 1'b0, 20'd0, 1'b0, 9};
        tbl[3] = '{pk(10, 0, 0, 0), pk(3, 0, 0, 0), 2'd0, 1'b1, 20'd38, 1'b0, 9};
        tbl[4] = '{pk(7, -3, 1, 2), pk(8'h01, 8'h02, 8'h03, 8'hFC), 2'd2, 1'b1, 20'd12, 1'b0, 3};
        tbl[5] = '{pk(-128, 127, 0, 0), pk(127, -128, 0, 0), 2'd3, 1'b1, 20'hF8100, 1'b0, 9};
        tbl[6] = '{pk(2, 0, 0, 0), pk(8'h07, 0, 0, 0), 2'd1, 1'b0, 20'd0, 1'b0, 5};
        tbl[7] = '{pk(1, 0, 0, 0), pk(8'hF0, 0, 0, 0), 2'd0, 1'b1, 20'hFFFFE, 1'b0, 9};

        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(out_result), 32'd0);
        check("rst_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            send(tbl[i].act, tbl[i].wgt, tbl[i].prec, tbl[i].last, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
            if (tbl[i].last) begin
                check($sformatf("vec%0d_result", i), 32'(out_result), 32'(tbl[i].exp_res));
                check($sformatf("vec%0d_ovf", i), 32'(out_ovf), 32'(tbl[i].exp_ovf));
                handshake();
            end else begin
                check($sformatf("vec%0d_no_valid", i), 32'(out_valid), 32'd0);
            end
        end

        // Positive saturation over nine -128*-128 vectors.
        for (int k = 0; k < 9; k++) begin
            send(pk(-128, -128, -128, -128), pk(-128, -128, -128, -128), 2'd0, (k == 8), lat);
            if (k == 6) begin
                check("sat_before", 32'(out_ovf), 32'd0);
            end
            if (k == 7) begin
                check("sat_ovf_sticky_early", 32'(out_ovf), 32'd1);
            end
        end
        check("sat_latency", 32'(lat), 32'd9);
        check("sat_result", 32'(out_result), 32'h7FFFF);
        check("sat_ovf", 32'(out_ovf), 32'd1);
        handshake();

        // Stall in HOLD with competing input traffic that must be ignored.
        send(pk(1, 2, 3, 4), pk(1, 1, 1, 1), 2'd0, 1'b1, lat);
        check("hold_latency", 32'(lat), 32'd9);
        held      = out_result;
        check("hold_value", 32'(held), 32'd10);
        in_valid  = 1'b1;
        in_act    = pk(9, 9, 9, 9);
        in_wgt    = pk(9, 9, 9, 9);
        in_last   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("hold_result", 32'(out_result), 32'd10);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
        end
        in_valid = 1'b0;
        handshake();

        // Reset mid-SHIFT discards the in-flight vector and a nonzero accumulator.
        send(pk(1, 0, 0, 0), pk(5, 0, 0, 0), 2'd0, 1'b0, lat);
        check("pre_rst_latency", 32'(lat), 32'd9);
        check("pre_rst_acc", 32'(out_result), 32'd5);
        in_valid = 1'b1;
        in_act   = pk(50, 50, 50, 50);
        in_wgt   = pk(50, 50, 50, 50);
        in_prec  = 2'd0;
        in_last  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("mid_busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_result", 32'(out_result), 32'd0);
        check("mid_rst_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        send(pk(2, 0, 0, 0), pk(3, 0, 0, 0), 2'd0, 1'b1, lat);
        check("post_rst_latency", 32'(lat), 32'd9);
        check("post_rst_result", 32'(out_result), 32'd6);
        handshake();

        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

endmodule

// File: doc/bit_serial_dot_engine.md
BIT_SERIAL_DOT_ENGINE -- requirements
Module: bit_serial_dot_engine

Interface
REQ-001 Parameter AW, default 8: signed two's-complement activation width per lane.
REQ-002 Parameter WW, default 8: max signed weight width per lane; SHALL be a multiple of 4.
REQ-003 Parameter LANES, default 4: parallel lanes summed into one dot product.
REQ-004 Parameter ACCW, default 20: accumulator width; SHALL be >= AW+WW+clog2(LANES).
REQ-005 clk  in  1  clock; all state changes on rising edge except async reset.
REQ-006 rstn  in  1  reset, asynchronous, active-low.
REQ-007 in_valid  in  1  input vector valid.
REQ-008 in_ready  out  1  engine can accept a vector.
REQ-009 in_act  in  LANES*AW  lane i activation at [i*AW +: AW], signed.
REQ-010 in_wgt  in  LANES*WW  lane i weight at [i*WW +: WW], signed.
REQ-011 in_prec  in  2  precision: 0 -> N=WW, 1 -> N=WW/2, 2 -> N=WW/4, 3 -> N=WW.
REQ-012 in_last  in  1  vector closes the current dot product.
REQ-013 out_valid  out  1  out_result valid.
REQ-014 out_ready  in  1  consumer accepts result.
REQ-015 out_result  out  ACCW  saturated signed accumulated dot product.
REQ-016 out_ovf  out  1  sticky saturation flag for current dot product.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states IDLE, SHIFT, ACC, HOLD; in_ready=1 only in IDLE.
REQ-019 Accept on edge T with in_valid&in_ready: latch act, wgt, N (from in_prec), last; go SHIFT; bit counter=0.
REQ-020 Weight uses only bits [N-1:0] per lane; bit N-1 is sign; upper bits ignored.
REQ-021 SHIFT: one weight bit per cycle LSB first, all lanes in parallel, edges T+1..T+N; bit k<N-1 adds act*2^k, bit N-1 subtracts act*2^(N-1) (two's-complement ~x+1).
REQ-022 Per-lane partial sums exact (AW+WW bits); lane products summed exactly before accumulation.
REQ-023 After bit N-1 go ACC; edge T+N+1 adds dot-product sum to accumulator, saturating to [-2^(ACCW-1), 2^(ACCW-1)-1].
REQ-024 Saturation sets out_ovf; it stays set until the output handshake.
REQ-025 After ACC: latched last=1 -> HOLD, out_valid=1 from edge T+N+1; last=0 -> IDLE, in_ready=1 from edge T+N+1.
REQ-026 HOLD: out_result and out_ovf stable, in_ready=0 until out_valid&out_ready.
REQ-027 On output handshake edge: accumulator<=0, out_ovf<=0, out_valid<=0, go IDLE.
REQ-028 out_result always shows the accumulator; consumers sample it only while out_valid=1.
REQ-029 Input changes while in_ready=0 SHALL be ignored; in_prec latched per vector, mixed precisions within one dot product allowed.
REQ-030 Latency acceptance->result: N+1 cycles; throughput one vector per N+2 cycles max.

Reset
REQ-031 rstn=0 at any time, including mid-SHIFT or HOLD: state IDLE, accumulator 0, counter 0, out_valid 0, out_ovf 0, busy 0, out_result 0; in_ready SHALL be 1 while rstn=0 and after.
REQ-032 A vector in flight during reset is discarded; no partial result is retained.

Verification (LANES=4, AW=8, WW=8, ACCW=20)
REQ-033 act={3,-2,5,1}, wgt={4,7,-1,-128}, prec 0, last=1 -> out_valid at T+9, out_result=0xFFF79 (-135), out_ovf=0.
REQ-034 act={5,5,5,5}, wgt={0xAF,0x0F,0x3F,0xFF}, prec 1, last=1 -> out_valid at T+5, out_result=-20 (0xFFFEC).
REQ-035 Vector1 act={1,1,1,1} wgt={2,2,2,2} last=0, then vector2 act={10,0,0,0} wgt={3,0,0,0} last=1 -> in_ready at T+9 after vector1, final out_result=38.
REQ-036 9 vectors act=all -128, wgt=all -128, last on 9th -> out_result=0x7FFFF, out_ovf=1; both cleared after handshake.
REQ-037 Hold out_ready=0 for 5 cycles in HOLD -> out_result stable, in_ready=0, busy=1; handshake -> IDLE next edge.
REQ-038 Assert rstn=0 at T+4 of a prec-0 vector -> all outputs reset values immediately; next vector computes from zero accumulator.
